jk_register: RTL and testbench

JK_REGISTER -- requirements
Module: jk_register

---
 rtl/jk_register.sv | 85 ++++++++
 tb/tb_jk_register.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/jk_register.sv
// jk_register: a bank of WIDTH JK flip-flops with extra operations.
// The extra operations are parallel load, shift-left and hold.
// It also has a registered complement output, a one-cycle "changed" pulse,
// and a saturating count of edges that altered the state.

module jk_register #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] _q,
    output logic             sout,
    output logic             changed,
    output logic [7:0]       chg_cnt
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_shift;
    logic             is_change;

    // A single-bit register shifts straight from sin.
    // Wider registers shift one bit left and take sin into the LSB.
    generate
        if (WIDTH == 1) begin : g_shift_one
            assign q_shift = sin;
        end else begin : g_shift_wide
            assign q_shift = {q[WIDTH-2:0], sin};
        end
    endgenerate

    // Select the next state. A low enable holds q; otherwise mode picks the operation.
    always_comb begin
        q_next = q;
        if (en) begin
            case (mode_t'(mode))
                MODE_JK:   q_next = (j & ~q) | (~k & q);
                MODE_LOAD: q_next = d;
                MODE_SHL:  q_next = q_shift;
                MODE_HOLD: q_next = q;
                default:   q_next = q;
            endcase
        end
    end

    assign is_change = (q_next != q);
    assign sout      = q[WIDTH-1];

    // State, complement, change pulse and change counter all update together.
    // The clear takes effect whether or not the register is enabled,
    // but a change on the same edge is still counted.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            q       <= RESET_VAL;
            _q      <= ~RESET_VAL;
            changed <= 1'b0;
            chg_cnt <= 8'd0;
        end else begin
            q       <= q_next;
            _q      <= ~q_next;
            changed <= is_change;
            if (cnt_clr) begin
                chg_cnt <= is_change ? 8'd1 : 8'd0;
            end else if (is_change && (chg_cnt != 8'd255)) begin
                chg_cnt <= chg_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_jk_register.sv
// tb_jk_register: directed and randomized checks of jk_register (WIDTH=8).
// Expected values come from a behavioural model kept in this bench.

module tb_jk_register;

    localparam int         WIDTH = 8;
    localparam logic [7:0] RVAL  = 8'h00;

    logic       clk;
    logic       _reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j, k, d;
    logic       sin;
    logic       cnt_clr;
    logic [7:0] q, _q;
    logic       sout;
    logic       changed;
    logic [7:0] chg_cnt;

    int nVectors = 0;
    int nMiscompares = 0;

    // Behavioural model state
    int mq;
    int mcnt;
    int mchanged;

    jk_register #(.WIDTH(WIDTH), .RESET_VAL(RVAL)) dut (
        .clk(clk), ._reset(_reset), .en(en), .mode(mode),
        .j(j), .k(k), .d(d), .sin(sin), .cnt_clr(cnt_clr),
        .q(q), ._q(_q), .sout(sout), .changed(changed), .chg_cnt(chg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_q"},       q,       mq[7:0]);
        checkOutput({tag, "_qn"},      _q,      (255 - mq) & 255);
        checkOutput({tag, "_sout"},    sout,    (mq >> 7) & 1);
        checkOutput({tag, "_changed"}, changed, mchanged);
        checkOutput({tag, "_chg_cnt"}, chg_cnt, mcnt);
    endtask

    task automatic modelReset();
        mq = RVAL;
        mcnt = 0;
        mchanged = 0;
    endtask

    // Advance the model by one edge using per-bit rules and plain arithmetic.
    task automatic modelStep(input int ven, input int vmode, input int vj, input int vk,
                             input int vd, input int vsin, input int vclr);
        int nxt;
        int bj, bk, bq;
        nxt = mq;
        if (ven != 0) begin
            if (vmode == 0) begin
                nxt = 0;
                for (int i = 0; i < 8; i++) begin
                    bj = (vj >> i) & 1;
                    bk = (vk >> i) & 1;
                    bq = (mq >> i) & 1;
                    if (bj == 1 && bk == 1)      bq = 1 - bq;
                    else if (bj == 1)            bq = 1;
                    else if (bk == 1)            bq = 0;
                    nxt = nxt + (bq << i);
                end
            end else if (vmode == 1) begin
                nxt = vd & 255;
            end else if (vmode == 2) begin
                nxt = (mq * 2 + vsin) % 256;
            end
        end
        mchanged = (nxt != mq) ? 1 : 0;
        if (vclr != 0)                     mcnt = mchanged;
        else if (mchanged == 1 && mcnt < 255) mcnt = mcnt + 1;
        mq = nxt;
    endtask

    task automatic applyStimulus(input logic ven, input logic [1:0] vmode, input logic [7:0] vj,
                                 input logic [7:0] vk, input logic [7:0] vd, input logic vsin,
                                 input logic vclr);
        @(negedge clk);
        en = ven; mode = vmode; j = vj; k = vk; d = vd; sin = vsin; cnt_clr = vclr;
        @(posedge clk);
        modelStep(ven, vmode, vj, vk, vd, vsin, vclr);
        #1;
    endtask

    initial begin
        _reset = 1'b0;
        en = 1'b0; mode = 2'b00; j = '0; k = '0; d = '0; sin = 1'b0; cnt_clr = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        _reset = 1'b1;

        // JK set upper nibble, clear lower nibble
        applyStimulus(1, 2'b00, 8'hF0, 8'h0F, 8'h00, 0, 0);
        checkAll("jk_setclr");
        checkOutput("jk_setclr_const", q, 8'hF0);

        // Toggle all bits twice
        applyStimulus(1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 0);
        checkAll("jk_toggle1");
        checkOutput("jk_toggle1_const", q, 8'h0F);
        applyStimulus(1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 0);
        checkAll("jk_toggle2");
        checkOutput("jk_toggle2_cnt", chg_cnt, 8'd3);

        // Load, shift, hold
        applyStimulus(1, 2'b01, 8'hFF, 8'hFF, 8'hA5, 1, 0);
        checkAll("load");
        checkOutput("load_const", q, 8'hA5);
        applyStimulus(1, 2'b10, 8'hFF, 8'hFF, 8'h00, 1, 0);
        checkAll("shift");
        checkOutput("shift_const", q, 8'h4B);
        checkOutput("shift_sout", sout, 1'b0);
        applyStimulus(1, 2'b11, 8'hFF, 8'hFF, 8'h00, 1, 0);
        checkAll("hold");
        checkOutput("hold_changed", changed, 1'b0);

        // Disabled load, then disabled with counter clear
        applyStimulus(0, 2'b01, 8'h00, 8'h00, 8'h55, 0, 0);
        checkAll("en_off");
        checkOutput("en_off_cnt", chg_cnt, 8'd5);
        applyStimulus(0, 2'b01, 8'h00, 8'h00, 8'h55, 0, 1);
        checkAll("en_off_clr");
        checkOutput("en_off_clr_cnt", chg_cnt, 8'd0);

        // Saturate the counter, then clear on a toggling edge
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 0);
            checkAll("sat");
        end
        checkOutput("sat_const", chg_cnt, 8'd255);
        applyStimulus(1, 2'b00, 8'hFF, 8'hFF, 8'h00, 0, 1);
        checkAll("clr_toggle");
        checkOutput("clr_toggle_const", chg_cnt, 8'd1);

        // Randomized operations
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          8'($urandom), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            checkAll("rand");
        end

        // Mid-cycle reset aborting a pending load
        applyStimulus(1, 2'b01, 8'h00, 8'h00, 8'h3C, 0, 0);
        checkAll("preload");
        @(negedge clk);
        en = 1'b1; mode = 2'b01; d = 8'hFF; cnt_clr = 1'b0;
        #2;
        _reset = 1'b0;
        modelReset();
        #1;
        checkAll("async_rst");
        mode = 2'b00; j = 8'hFF; k = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checkAll("held_rst");
        @(negedge clk);
        en = 1'b0;
        #2;
        _reset = 1'b1;
        #1;
        checkAll("rst_release");
        @(posedge clk);
        modelStep(0, 0, 255, 255, 0, 0, 0);
        #1;
        checkAll("post_release");
        applyStimulus(1, 2'b00, 8'h81, 8'h00, 8'h00, 0, 0);
        checkAll("post_release_jk");

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
